// File: rtl/tkeo_spike_detector_if.sv
// tkeo_spike_detector_if: energy stream in, threshold controls, and spike report out.
// master drives the stream and controls; slave is the detector.
interface tkeo_spike_detector_if #(
    parameter int unsigned IN_BITS = 29
);
    logic               in_valid;
    logic [IN_BITS-1:0] energy_in;
    logic [7:0]         thr_mult;
    logic [IN_BITS-1:0] thr_floor;
    logic               spike_valid;
    logic [IN_BITS-1:0] spike_peak;
    logic [7:0]         spike_width;
    logic [IN_BITS+3:0] threshold;
    logic               busy;

    modport master (
        output in_valid, energy_in, thr_mult, thr_floor,
        input  spike_valid, spike_peak, spike_width, threshold, busy
    );

    modport slave (
        input  in_valid, energy_in, thr_mult, thr_floor,
        output spike_valid, spike_peak, spike_width, threshold, busy
    );
endinterface

// File: rtl/tkeo_spike_detector.sv
// tkeo_spike_detector: EMA-baselined threshold detector on the TKEO energy stream.
// Each supra-threshold run is reported once (peak, width), then a refractory window follows.
// Build macro SPIKE_COUNT_EN adds cnt_clr / spike_count (saturating 16-bit event counter).
module tkeo_spike_detector #(
    parameter int unsigned IN_BITS     = 29,
    parameter int unsigned ALPHA_SH    = 4,
    parameter int unsigned WARMUP_LEN  = 16,
    parameter int unsigned REFRACT_LEN = 32,
    parameter int unsigned MAX_EVT_LEN = 64
) (
    input  logic clk,
    input  logic rst,
`ifdef SPIKE_COUNT_EN
    input  logic        cnt_clr,
    output logic [15:0] spike_count,
`endif
    tkeo_spike_detector_if.slave bus
);

    typedef enum logic [1:0] {WARMUP, ARMED, EVENT, REFRACT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IN_BITS-1:0] baseline_q, baseline_d;
    logic [IN_BITS-1:0] peak_q, peak_d;
    logic [7:0]         width_q, width_d;
    logic               spike_valid_q, spike_valid_d;
    logic [IN_BITS-1:0] spike_peak_q, spike_peak_d;
    logic [7:0]         spike_width_q, spike_width_d;

    logic [IN_BITS+7:0]   prod;
    logic [IN_BITS+3:0]   scaled;
    logic [IN_BITS+3:0]   floor_ext;
    logic [IN_BITS+3:0]   thr;
    logic [IN_BITS+3:0]   energy_ext;
    logic                 hit;
    logic signed [IN_BITS:0] diff;
    logic [IN_BITS-1:0]   ema_next;

    // Threshold and EMA step derived from the registered baseline and current sample
    always_comb begin
        prod       = {8'b0, baseline_q} * {{IN_BITS{1'b0}}, bus.thr_mult};
        scaled     = (IN_BITS+4)'(prod >> 4);
        floor_ext  = {4'b0, bus.thr_floor};
        thr        = (scaled > floor_ext) ? scaled : floor_ext;
        energy_ext = {4'b0, bus.energy_in};
        hit        = energy_ext > thr;
        diff       = $signed({1'b0, bus.energy_in}) - $signed({1'b0, baseline_q});
        // The floored step keeps baseline+step between the old baseline and the sample,
        // so modular IN_BITS addition of the truncated step is exact.
        ema_next   = baseline_q + IN_BITS'(diff >>> ALPHA_SH);
    end

    // Next-state and datapath update; nothing advances unless a sample is presented
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        baseline_d    = baseline_q;
        peak_d        = peak_q;
        width_d       = width_q;
        spike_valid_d = 1'b0;
        spike_peak_d  = spike_peak_q;
        spike_width_d = spike_width_q;
        if (bus.in_valid) begin
            unique case (state_q)
                WARMUP: begin
                    baseline_d = (cnt_q == '0) ? bus.energy_in : ema_next;
                    if (cnt_q == 8'(WARMUP_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ARMED: begin
                    if (hit) begin
                        state_d = EVENT;
                        peak_d  = bus.energy_in;
                        width_d = 8'd1;
                    end else begin
                        baseline_d = ema_next;
                    end
                end
                EVENT: begin
                    if (hit && (width_q < 8'(MAX_EVT_LEN))) begin
                        width_d = width_q + 8'd1;
                        if (bus.energy_in > peak_q) peak_d = bus.energy_in;
                    end else begin
                        spike_valid_d = 1'b1;
                        spike_peak_d  = peak_q;
                        spike_width_d = width_q;
                        cnt_d         = '0;
                        state_d       = REFRACT;
                    end
                end
                REFRACT: begin
                    if (cnt_q == 8'(REFRACT_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = WARMUP;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WARMUP;
            cnt_q         <= '0;
            baseline_q    <= '0;
            peak_q        <= '0;
            width_q       <= '0;
            spike_valid_q <= 1'b0;
            spike_peak_q  <= '0;
            spike_width_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            baseline_q    <= baseline_d;
            peak_q        <= peak_d;
            width_q       <= width_d;
            spike_valid_q <= spike_valid_d;
            spike_peak_q  <= spike_peak_d;
            spike_width_q <= spike_width_d;
        end
    end

    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_peak  = spike_peak_q;
    assign bus.spike_width = spike_width_q;
    assign bus.threshold   = thr;
    assign bus.busy        = (state_q == EVENT) || (state_q == REFRACT);

`ifdef SPIKE_COUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating event count; a clear wins over a coincident pulse
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (spike_valid_q && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Event counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign spike_count = count_q;
`endif

endmodule

// File: tb/tb_tkeo_spike_detector.sv
// tb_tkeo_spike_detector: directed scenarios plus randomized stream against a sample-level model.
module tb_tkeo_spike_detector;
    localparam int IN_BITS = 29;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tkeo_spike_detector_if #(.IN_BITS(IN_BITS)) bus ();

`ifdef SPIKE_COUNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] spike_count;
`endif

    tkeo_spike_detector #(
        .IN_BITS    (IN_BITS),
        .ALPHA_SH   (4),
        .WARMUP_LEN (16),
        .REFRACT_LEN(32),
        .MAX_EVT_LEN(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SPIKE_COUNT_EN
        .cnt_clr    (cnt_clr),
        .spike_count(spike_count),
`endif
        .bus        (bus)
    );

    int nerr = 0;
    int nchk = 0;
    bit check_en = 0;

    // Sample-level model state
    longint m_base;
    int     warm_left, refract_left, ev_width;
    bit     in_event;
    longint ev_peak;
    bit     exp_sv;
    longint exp_peak, exp_width;
    longint exp_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model_thr();
        longint s, f;
        s = (m_base * longint'(bus.thr_mult)) >> 4;
        f = longint'(bus.thr_floor);
        return (s > f) ? s : f;
    endfunction

    task automatic model_reset();
        m_base = 0; warm_left = 16; refract_left = 0; in_event = 0;
        ev_width = 0; ev_peak = 0; exp_sv = 0; exp_peak = 0; exp_width = 0; exp_cnt = 0;
    endtask

    task automatic model_apply(input bit v, input longint e);
        longint t;
        bit h;
`ifdef SPIKE_COUNT_EN
        if (cnt_clr) exp_cnt = 0;
        else if (exp_sv && exp_cnt < 65535) exp_cnt++;
`endif
        exp_sv = 0;
        if (!v) return;
        t = model_thr();
        h = e > t;
        if (warm_left > 0) begin
            if (warm_left == 16) m_base = e;
            else m_base = m_base + ((e - m_base) >>> 4);
            warm_left--;
        end else if (in_event) begin
            if (h && ev_width < 64) begin
                ev_width++;
                if (e > ev_peak) ev_peak = e;
            end else begin
                exp_sv = 1; exp_peak = ev_peak; exp_width = ev_width;
                in_event = 0; refract_left = 32;
            end
        end else if (refract_left > 0) begin
            refract_left--;
        end else if (h) begin
            in_event = 1; ev_peak = e; ev_width = 1;
        end else begin
            m_base = m_base + ((e - m_base) >>> 4);
        end
    endtask

    task automatic step(input bit v, input longint e);
        @(negedge clk);
        bus.in_valid  = v;
        bus.energy_in = e[IN_BITS-1:0];
        model_apply(v, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        check_en = 0;
        model_reset();
        #1;
        chk("rst_spike_valid", longint'(bus.spike_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_peak", longint'(bus.spike_peak), 0);
        chk("rst_width", longint'(bus.spike_width), 0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1;
    endtask

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #2;
        if (check_en && !rst) begin
            chk("spike_valid", longint'(bus.spike_valid), longint'(exp_sv));
            chk("spike_peak", longint'(bus.spike_peak), exp_peak);
            chk("spike_width", longint'(bus.spike_width), exp_width);
            chk("busy", longint'(bus.busy), longint'(in_event || refract_left > 0));
            chk("threshold", longint'(bus.threshold), model_thr());
`ifdef SPIKE_COUNT_EN
            chk("spike_count", longint'(spike_count), exp_cnt);
`endif
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int burst;
        bit v;
        longint e;
        bus.in_valid = 1'b0;
        bus.energy_in = '0;
        bus.thr_mult = 8'h40;
        bus.thr_floor = 100;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Warmup on a flat 1000 stream
        repeat (16) step(1, 1000);
        chk("warm_thr", longint'(bus.threshold), 4000);
        chk("warm_busy", longint'(bus.busy), 0);

        // Basic event
        step(1, 5000);
        chk("ev_busy", longint'(bus.busy), 1);
        step(1, 9000);
        step(1, 6000);
        step(1, 1000);
        chk("ev_valid", longint'(bus.spike_valid), 1);
        chk("ev_peak", longint'(bus.spike_peak), 9000);
        chk("ev_width", longint'(bus.spike_width), 3);

        // Refractory: spike at +10 ignored, spike at +33 opens an event
        for (int k = 1; k <= 32; k++) begin
            step(1, (k == 10) ? 9000 : 1000);
            if (k == 11) chk("refract_no_pulse", longint'(bus.spike_valid), 0);
        end
        chk("refract_done_busy", longint'(bus.busy), 0);
        step(1, 9000);
        chk("reopen_busy", longint'(bus.busy), 1);
        step(1, 1000);
        chk("reopen_valid", longint'(bus.spike_valid), 1);
        chk("reopen_width", longint'(bus.spike_width), 1);
        repeat (32) step(1, 1000);

        // Max width force-close
        for (int i = 1; i <= 70; i++) begin
            step(1, 9000);
            if (i == 64) chk("maxw_no_early", longint'(bus.spike_valid), 0);
            if (i == 65) begin
                chk("maxw_valid", longint'(bus.spike_valid), 1);
                chk("maxw_width", longint'(bus.spike_width), 64);
                chk("maxw_peak", longint'(bus.spike_peak), 9000);
            end
        end
`ifdef SPIKE_COUNT_EN
        chk("count3", longint'(spike_count), 3);
`endif
        repeat (27) step(1, 1000);

        // Floor and strict comparison, with gaps
        do_reset();
        repeat (16) step(1, 0);
        chk("floor_thr", longint'(bus.threshold), 100);
        step(1, 100);
        chk("floor_eq_busy", longint'(bus.busy), 0);
        step(0, 5000);
        step(0, 5000);
        chk("gap_busy", longint'(bus.busy), 0);
        step(1, 101);
        chk("floor_101_busy", longint'(bus.busy), 1);
        step(0, 0);
        step(1, 0);
        chk("floor_valid", longint'(bus.spike_valid), 1);
        chk("floor_peak", longint'(bus.spike_peak), 101);
        chk("floor_width", longint'(bus.spike_width), 1);
`ifdef SPIKE_COUNT_EN
        cnt_clr = 1'b1;
        step(1, 0);
        cnt_clr = 1'b0;
        chk("clr_coincident", longint'(spike_count), 0);
        repeat (31) step(1, 0);
`else
        repeat (32) step(1, 0);
`endif

        // Reset in the middle of an event
        step(1, 500);
        chk("mid_busy", longint'(bus.busy), 1);
        do_reset();
        repeat (16) step(1, 0);
        chk("post_rst_busy", longint'(bus.busy), 0);

        // Randomized stream
        for (int seg = 0; seg < 8; seg++) begin
            if (seg % 3 == 0) do_reset();
            bus.thr_mult  = 8'($urandom_range(8, 128));
            bus.thr_floor = IN_BITS'($urandom_range(0, 3000));
            burst = 0;
            repeat (400) begin
                if ($urandom_range(0, 49) == 0) bus.thr_mult = 8'($urandom_range(0, 255));
                v = ($urandom_range(0, 3) != 0);
                if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 80);
                if (burst > 0) begin
                    e = longint'($urandom_range(20000, 32'h1FFFFFFF));
                    if ($urandom_range(0, 15) == 0) e = 64'h1FFFFFFF;
                    burst--;
                end else begin
                    e = longint'($urandom_range(0, 2000));
                end
`ifdef SPIKE_COUNT_EN
                cnt_clr = ($urandom_range(0, 19) == 0);
`endif
                step(v, e);
            end
        end
`ifdef SPIKE_COUNT_EN
        cnt_clr = 1'b0;
`endif
        step(0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
